// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the ID/EX stage and its load-use hazard detector:
// hazard FSM state encoding, control-bundle width, stall-counter width and
// the default parameter values used by both modules.
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } hz_state_e;

    localparam int DEF_NB_DATA      = 32;
    localparam int DEF_NB_ADDR      = 5;
    localparam int DEF_NB_ALUOP     = 3;
    localparam int DEF_STALL_CYCLES = 1;

    // mem_read, mem_write, reg_write, mem_to_reg, alu_src, reg_dst
    localparam int CTRL_FLAG_W = 6;
    // Full control bundle: the six flags plus the ALU op
    localparam int CTRL_W      = CTRL_FLAG_W + DEF_NB_ALUOP;

    localparam int CNT_W = 3;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector
// Detects a load in EX whose destination (rt) feeds the instruction in ID and
// holds o_stall high for STALL_CYCLES consecutive cycles.
//
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_enable, i_flush     pipeline enable, branch/jump squash
//   i_valid, i_rs, i_rt   ID instruction validity and source registers
//   i_ex_valid,
//   i_ex_mem_read, i_ex_rt  instruction currently registered in EX
//   o_stall               freeze PC and IF/ID, bubble into EX
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | no stall in progress; hazard detection armed
// BUBBLE | extra stall cycles after detection, count tracks cycles done
module load_use_detector
    import pipeline_pkg::*;
#(
    parameter int NB_ADDR      = DEF_NB_ADDR,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_ADDR-1:0] i_rs,
    input  logic [NB_ADDR-1:0] i_rt,
    input  logic               i_ex_valid,
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    output logic               o_stall
);

    localparam bit                MULTI_CYCLE = (STALL_CYCLES > 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT  = CNT_W'(STALL_CYCLES - 1);

    hz_state_e        state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             hazard;

    // Register 0 is deliberately not special-cased.
    assign hazard = (state == RUN) && i_valid && i_ex_valid && i_ex_mem_read &&
                    ((i_ex_rt == i_rs) || (i_ex_rt == i_rt));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        if (i_flush) begin
            state_next = RUN;
            count_next = '0;
        end else if (i_enable) begin
            case (state)
                RUN: begin
                    // Detection cycle is stall #1; BUBBLE covers the rest.
                    if (hazard && MULTI_CYCLE) begin
                        state_next = BUBBLE;
                        count_next = CNT_W'(1);
                    end
                end
                BUBBLE: begin
                    if (count == LAST_COUNT) begin
                        state_next = RUN;
                        count_next = '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                    count_next = '0;
                end
            endcase
        end
    end

    // Reset and flush win over any stall in the same cycle; a disabled
    // pipeline never reports a stall.
    always_comb begin
        o_stall = 1'b0;
        if (!i_reset && !i_flush && i_enable) begin
            o_stall = hazard || (state == BUBBLE);
        end
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
// ID/EX pipeline register with load-use stall/bubble insertion and optional
// write-back bypass of the register-bank read data.
//
// Build option: ID_EX_WB_BYPASS_EN -- when defined, the WB write port is
// registered each enabled cycle and forwarded over i_data_a/i_data_b on a
// matching rs/rt, covering a bank write that lands on the same edge as the
// bank's registered read. Undefined: i_wb_* are ignored.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_enable, i_flush       debug-unit enable, branch/jump squash
//   i_valid                 ID holds a real instruction
//   i_data_a/b, i_imm       bank read data, sign-extended immediate
//   i_rs/rt/rd              decoded register fields
//   i_mem_read..i_alu_op    decoded controls
//   i_wb_*                  write-back port (same as driven to the bank)
//   o_stall                 freeze PC and IF/ID
//   o_valid, o_*            registered EX copies of the above
module id_ex_hazard_stage
    import pipeline_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int NB_ADDR      = DEF_NB_ADDR,
    parameter int NB_ALUOP     = DEF_NB_ALUOP,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data_a,
    input  logic [NB_DATA-1:0]  i_data_b,
    input  logic [NB_ADDR-1:0]  i_rs,
    input  logic [NB_ADDR-1:0]  i_rt,
    input  logic [NB_ADDR-1:0]  i_rd,
    input  logic [NB_DATA-1:0]  i_imm,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic                i_reg_write,
    input  logic                i_mem_to_reg,
    input  logic                i_alu_src,
    input  logic                i_reg_dst,
    input  logic [NB_ALUOP-1:0] i_alu_op,
    input  logic                i_wb_reg_write,
    input  logic [NB_ADDR-1:0]  i_wb_write_reg,
    input  logic [NB_DATA-1:0]  i_wb_write_data,
    output logic                o_stall,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_data_a,
    output logic [NB_DATA-1:0]  o_data_b,
    output logic [NB_ADDR-1:0]  o_rs,
    output logic [NB_ADDR-1:0]  o_rt,
    output logic [NB_ADDR-1:0]  o_rd,
    output logic [NB_DATA-1:0]  o_imm,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic                o_alu_src,
    output logic                o_reg_dst,
    output logic [NB_ALUOP-1:0] o_alu_op
);

    localparam int NB_CTRL = CTRL_FLAG_W + NB_ALUOP;

    logic               stall;
    logic [NB_CTRL-1:0] ctrl_in, ctrl_q;
    logic [NB_DATA-1:0] data_a_sel, data_b_sel;

    assign ctrl_in = {i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg,
                      i_alu_src, i_reg_dst, i_alu_op};
    assign {o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg,
            o_alu_src, o_reg_dst, o_alu_op} = ctrl_q;
    assign o_stall = stall;

    load_use_detector #(
        .NB_ADDR      (NB_ADDR),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_load_use_detector (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .i_rs          (i_rs),
        .i_rt          (i_rt),
        .i_ex_valid    (o_valid),
        .i_ex_mem_read (o_mem_read),
        .i_ex_rt       (o_rt),
        .o_stall       (stall)
    );

`ifdef ID_EX_WB_BYPASS_EN
    logic               wb_q_reg_write;
    logic [NB_ADDR-1:0] wb_q_write_reg;
    logic [NB_DATA-1:0] wb_q_write_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wb_q_reg_write  <= 1'b0;
            wb_q_write_reg  <= '0;
            wb_q_write_data <= '0;
        end else if (i_enable) begin
            wb_q_reg_write  <= i_wb_reg_write;
            wb_q_write_reg  <= i_wb_write_reg;
            wb_q_write_data <= i_wb_write_data;
        end
    end

    assign data_a_sel = (wb_q_reg_write && (wb_q_write_reg == i_rs)) ? wb_q_write_data : i_data_a;
    assign data_b_sel = (wb_q_reg_write && (wb_q_write_reg == i_rt)) ? wb_q_write_data : i_data_b;
`else
    logic unused_wb;
    assign unused_wb  = ^{i_wb_reg_write, i_wb_write_reg, i_wb_write_data};
    assign data_a_sel = i_data_a;
    assign data_b_sel = i_data_b;
`endif

    // Bubbles clear only validity and controls; data/address fields hold.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            ctrl_q   <= '0;
            o_data_a <= '0;
            o_data_b <= '0;
            o_rs     <= '0;
            o_rt     <= '0;
            o_rd     <= '0;
            o_imm    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            ctrl_q  <= '0;
        end else if (i_enable) begin
            if (stall) begin
                o_valid <= 1'b0;
                ctrl_q  <= '0;
            end else begin
                o_valid  <= i_valid;
                ctrl_q   <= ctrl_in;
                o_data_a <= data_a_sel;
                o_data_b <= data_b_sel;
                o_rs     <= i_rs;
                o_rt     <= i_rt;
                o_rd     <= i_rd;
                o_imm    <= i_imm;
            end
        end
    end

endmodule
